// File: rtl/axi_rand_source.sv
// Pseudo-random word source: Galois LFSR feeding a small FIFO, words offered to a channel stage
// with a one-cycle en_o pulse and popped on the cs handshake. Optional feature: RAND_SRC_SKIP_EN.
module axi_rand_source #(
    parameter int unsigned          DATA_W     = 32,
    parameter int unsigned          FIFO_DEPTH = 4,
    parameter logic [DATA_W-1:0]    SEED       = DATA_W'(32'hACE1_2468),
    parameter logic [DATA_W-1:0]    POLY       = DATA_W'(32'h8020_0003),
    localparam int unsigned         LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              anreset,
    input  logic              enable,
    input  logic              seed_load,
    input  logic [DATA_W-1:0] seed_val,
    input  logic              cs,
    output logic              en_o,
    output logic [DATA_W-1:0] data,
`ifdef RAND_SRC_SKIP_EN
    output logic [15:0]       skip_cnt,
`endif
    output logic [LVL_W-1:0]  level
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OFFER   = 2'd1,
        WAIT_CS = 2'd2
    } state_e;

    state_e              state_q;
    logic [DATA_W-1:0]   lfsr_q;
    logic [DATA_W-1:0]   lfsr_d;
    logic [DATA_W-1:0]   lfsr_step;
    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q;
    logic [AW-1:0]       rd_ptr_q;
    logic [LVL_W-1:0]    level_q;
    logic                full;
    logic                push;
    logic                pop;

    assign lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? POLY : '0);
    // Fullness is taken from the registered level, so a same-cycle pop never frees a slot early.
    assign full      = (level_q == LVL_W'(FIFO_DEPTH));
    assign push      = enable & ~full & ~seed_load;
    assign pop       = (state_q == WAIT_CS) & cs;

    always_comb begin
        lfsr_d = lfsr_q;
        if (seed_load) begin
            lfsr_d = (seed_val == '0) ? SEED : seed_val;
        end else if (push) begin
            lfsr_d = lfsr_step;
`ifdef RAND_SRC_SKIP_EN
        end else if (enable) begin
            lfsr_d = lfsr_step;
`endif
        end
    end

    always_ff @(posedge clk or negedge anreset) begin
        if (!anreset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Storage carries no reset: contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= lfsr_q;
        end
    end

    always_ff @(posedge clk or negedge anreset) begin
        if (!anreset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Offer sequencer: one en_o cycle per word, then hold until the handshake.
    always_ff @(posedge clk or negedge anreset) begin
        if (!anreset) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:    state_q <= (level_q != '0) ? OFFER : IDLE;
                OFFER:   state_q <= WAIT_CS;
                WAIT_CS: state_q <= cs ? IDLE : WAIT_CS;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef RAND_SRC_SKIP_EN
    logic [15:0] skip_cnt_q;

    always_ff @(posedge clk or negedge anreset) begin
        if (!anreset) begin
            skip_cnt_q <= '0;
        end else if (enable && full && !seed_load && (skip_cnt_q != 16'hFFFF)) begin
            skip_cnt_q <= skip_cnt_q + 16'd1;
        end
    end

    assign skip_cnt = skip_cnt_q;
`endif

    assign en_o  = (state_q == OFFER);
    assign data  = mem_q[rd_ptr_q];
    assign level = level_q;

endmodule

// File: tb/tb_axi_rand_source.sv
// Randomized bench for axi_rand_source against a queue-based reference model and a simple
// valid/ready channel stage model. Build with RAND_SRC_SKIP_EN to exercise the skip counter.
module tb_axi_rand_source;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] SEED  = 32'hACE1_2468;
    localparam logic [31:0] POLY  = 32'h8020_0003;

    logic        clk = 1'b0;
    logic        anreset;
    logic        enable;
    logic        seed_load;
    logic [31:0] seed_val;
    logic        cs;
    logic        en_o;
    logic [31:0] data;
    logic [2:0]  level;
`ifdef RAND_SRC_SKIP_EN
    logic [15:0] skip_cnt;
`endif

    axi_rand_source dut (
        .clk       (clk),
        .anreset   (anreset),
        .enable    (enable),
        .seed_load (seed_load),
        .seed_val  (seed_val),
        .cs        (cs),
        .en_o      (en_o),
        .data      (data),
`ifdef RAND_SRC_SKIP_EN
        .skip_cnt  (skip_cnt),
`endif
        .level     (level)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model state
    logic [31:0] mdl_q [$];
    logic [31:0] mdl_lfsr;
    logic [15:0] mdl_skip;
    logic        ch_valid;
    logic [31:0] offer_data;
    logic        prev_en;
    int unsigned n_offers;
    logic [31:0] popped [$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? POLY : 32'h0);
    endfunction

    task automatic model_reset();
        mdl_q.delete();
        mdl_lfsr = SEED;
        mdl_skip = 16'h0;
        ch_valid = 1'b0;
        prev_en  = 1'b0;
        n_offers = 0;
        popped.delete();
    endtask

    // One clock: check outputs left by the last edge, then apply inputs for the next edge.
    task automatic step(input logic en, input logic sl, input logic [31:0] sv, input logic rdy);
        logic full;
        logic hs;
        @(negedge clk);
        check("level", 32'(level), 32'(mdl_q.size()));
`ifdef RAND_SRC_SKIP_EN
        check("skip_cnt", 32'(skip_cnt), 32'(mdl_skip));
`endif
        if (en_o) begin
            n_offers++;
            check("offer_while_valid", 32'(ch_valid), 32'd0);
            check("offer_on_empty", 32'(mdl_q.size() != 0), 32'd1);
            check("en_pulse_width", 32'(prev_en), 32'd0);
            offer_data = data;
        end
        prev_en   = en_o;
        enable    = en;
        seed_load = sl;
        seed_val  = sv;
        hs        = ch_valid & rdy;
        cs        = hs;
        if (hs) begin
            check("data_at_cs", data, mdl_q[0]);
            check("data_hold", data, offer_data);
            popped.push_back(data);
        end
        full = (mdl_q.size() == DEPTH);
        if (sl) begin
            mdl_lfsr = (sv == 32'h0) ? SEED : sv;
        end else if (en && !full) begin
            mdl_q.push_back(mdl_lfsr);
            mdl_lfsr = lfsr_next(mdl_lfsr);
        end else if (en) begin
`ifdef RAND_SRC_SKIP_EN
            mdl_lfsr = lfsr_next(mdl_lfsr);
            if (mdl_skip != 16'hFFFF) mdl_skip = mdl_skip + 16'd1;
`endif
        end
        if (hs) void'(mdl_q.pop_front());
        if (en_o)     ch_valid = 1'b1;
        else if (hs)  ch_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        anreset   = 1'b0;
        enable    = 1'b0;
        seed_load = 1'b0;
        seed_val  = 32'h0;
        cs        = 1'b0;
        #1;
        check("rst_en_o", 32'(en_o), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        anreset = 1'b1;
    endtask

    initial begin
        int first_offer;
        logic [31:0] exp_word;
        anreset   = 1'b0;
        enable    = 1'b0;
        seed_load = 1'b0;
        seed_val  = 32'h0;
        cs        = 1'b0;
        offer_data = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);
        anreset = 1'b1;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0);
            check("idle_en_o", 32'(en_o), 32'd0);
        end

        // Streaming with ready high: latency and first words
        do_reset();
        first_offer = -1;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1);
            if (en_o && first_offer < 0) first_offer = i;
        end
        for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
        check("offer_latency", 32'(first_offer), 32'd2);
        check("word0", popped[0], 32'hACE1_2468);
        check("word1", popped[1], 32'h5670_9234);
        check("offers_per_word", 32'(n_offers), 32'(popped.size()));

        // Back-pressure: FIFO fills, one offer, head held
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check("sat_level", 32'(level), 32'd4);
        check("sat_offers", 32'(n_offers), 32'd1);
        check("sat_data", data, 32'hACE1_2468);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Seed loading
        popped.delete();
        step(1'b1, 1'b1, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h1, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
        check("seed0_word", popped[0], 32'hACE1_2468);
        check("seed1_word0", popped[1], 32'h0000_0001);
        check("seed1_word1", popped[2], 32'h8020_0003);

        // Reset while waiting for the handshake
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        check("pre_rst_level", 32'(level), 32'd3);
        check("pre_rst_waiting", 32'(ch_valid), 32'd1);
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
        check("post_rst_word", popped[0], 32'hACE1_2468);

`ifdef RAND_SRC_SKIP_EN
        // Free-running LFSR while full
        do_reset();
        for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check("skip_10", 32'(skip_cnt), 32'd10);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
        popped.delete();
        step(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
        exp_word = SEED;
        for (int i = 0; i < 14; i++) exp_word = lfsr_next(exp_word);
        check("skip_next_word", popped[0], exp_word);
`else
        exp_word = 32'h0;
`endif

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic [31:0] sv;
            sv = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0), sv,
                 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
        check("final_level", 32'(level), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
